// File: rtl/pill_pkg.sv
// Shared types and timing constants for the pill hopper simulator and its
// button conditioning logic.
package pill_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE_HI = 2'd1,
        PULSE_LO = 2'd2,
        EMPTY    = 2'd3
    } feeder_state_t;

    localparam int CLK_HZ       = 1000;
    localparam int PILL_PERIOD  = 1000;
    localparam int DEBOUNCE_CYC = 20;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises a push-button/switch and emits a one-cycle pulse on its rising
// edge. PILL_FEEDER_ADD_DEBOUNCE_EN adds a DEBOUNCE_CYC-cycle stability filter.
import pill_pkg::*;

module btn_sync_edge (
    input  logic clk_1khz,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [1:0] sync_reg;
    logic       clean;
    logic       edge_reg;

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

`ifdef PILL_FEEDER_ADD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic             filt_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The filtered level only follows the input after it has disagreed for
    // DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            filt_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (sync_reg[1] != filt_reg) begin
            if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                filt_reg <= sync_reg[1];
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    assign clean = filt_reg;
`else
    assign clean = sync_reg[1];
`endif

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            edge_reg <= 1'b0;
        end else begin
            edge_reg <= clean;
        end
    end

    assign rise = clean & ~edge_reg;

endmodule

// File: rtl/pill_feeder_sim.sv
// Pill hopper model: one fixed-width pulse per dispensed pill, finite inventory
// with refill, hopper/conveyor interlocks. Refill debounce: PILL_FEEDER_ADD_DEBOUNCE_EN.
import pill_pkg::*;

module pill_feeder_sim #(
    parameter int PERIOD     = PILL_PERIOD,
    parameter int PULSE_W    = CLK_HZ / 2,
    parameter int CAPACITY   = 99,
    parameter int REFILL_AMT = 50,
    parameter int INIT_LEVEL = 99,
    parameter int LEVEL_W    = 7
) (
    input  logic               clk_1khz,
    input  logic               rst,
    input  logic               feed_en,
    input  logic               hopper_stop,
    input  logic               conveyor_stop,
    input  logic               hopper_add,
    output logic               pill_pulse,
    output logic [LEVEL_W-1:0] hopper_level,
    output logic               hopper_empty,
    output logic               feeding,
    output logic [15:0]        dispensed_cnt
);

    localparam int PHASE_W = $clog2(PERIOD);
    localparam int SUM_W   = LEVEL_W + 1;
    localparam logic [PHASE_W-1:0] HI_LAST = PHASE_W'(PULSE_W - 1);
    localparam logic [PHASE_W-1:0] LO_LAST = PHASE_W'(PERIOD - PULSE_W - 1);

    feeder_state_t      state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [SUM_W-1:0]   level_sum;
    logic [15:0]        cnt_reg;
    logic               pulse_reg;
    logic               empty_reg;
    logic               ok;
    logic               has_pills;
    logic               pill_start;
    logic               refill;

    btn_sync_edge u_add_edge (
        .clk_1khz (clk_1khz),
        .rst      (rst),
        .btn      (hopper_add),
        .rise     (refill)
    );

    assign ok        = feed_en & ~hopper_stop & ~conveyor_stop;
    assign has_pills = (level_reg != '0);

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg + PHASE_W'(1);
        pill_start = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next = '0;
                if (ok) begin
                    if (has_pills) begin
                        state_next = PULSE_HI;
                        pill_start = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            // Interlocks are deliberately not looked at while the pulse is high.
            PULSE_HI: begin
                if (phase_reg == HI_LAST) begin
                    state_next = PULSE_LO;
                    phase_next = '0;
                end
            end
            PULSE_LO: begin
                if (phase_reg == LO_LAST) begin
                    phase_next = '0;
                    if (!ok) begin
                        state_next = IDLE;
                    end else if (has_pills) begin
                        state_next = PULSE_HI;
                        pill_start = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            EMPTY: begin
                phase_next = '0;
                if (has_pills) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Decrement and refill are merged in one extra-wide sum so neither is lost.
    always_comb begin
        level_sum = {1'b0, level_reg};
        if (pill_start) begin
            level_sum = level_sum - SUM_W'(1);
        end
        if (refill) begin
            level_sum = level_sum + SUM_W'(REFILL_AMT);
        end
        level_next = (level_sum > SUM_W'(CAPACITY)) ? LEVEL_W'(CAPACITY)
                                                     : level_sum[LEVEL_W-1:0];
    end

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            level_reg <= LEVEL_W'(INIT_LEVEL);
            pulse_reg <= 1'b0;
            empty_reg <= (INIT_LEVEL == 0);
            cnt_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            level_reg <= level_next;
            pulse_reg <= (state_next == PULSE_HI);
            empty_reg <= (state_next == EMPTY);
            if (pill_start) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign pill_pulse    = pulse_reg;
    assign hopper_level  = level_reg;
    assign hopper_empty  = empty_reg;
    assign feeding       = (state_reg == PULSE_HI) || (state_reg == PULSE_LO);
    assign dispensed_cnt = cnt_reg;

endmodule

// File: tb/tb_pill_feeder_sim.sv
// Directed bench for pill_feeder_sim (PERIOD=10, PULSE_W=4, CAPACITY=20,
// REFILL_AMT=8, INIT_LEVEL=3); refill timing follows PILL_FEEDER_ADD_DEBOUNCE_EN.
module tb_pill_feeder_sim;

    localparam int PERIOD     = 10;
    localparam int PULSE_W    = 4;
    localparam int CAPACITY   = 20;
    localparam int REFILL_AMT = 8;
    localparam int INIT_LEVEL = 3;
    localparam int LEVEL_W    = 7;

    // Ticks from raising hopper_add until the new level is visible.
`ifdef PILL_FEEDER_ADD_DEBOUNCE_EN
    localparam int ADD_TICKS = 23;
`else
    localparam int ADD_TICKS = 3;
`endif

    logic               clk_1khz = 1'b0;
    logic               rst = 1'b1;
    logic               feed_en = 1'b0;
    logic               hopper_stop = 1'b0;
    logic               conveyor_stop = 1'b0;
    logic               hopper_add = 1'b0;
    logic               pill_pulse;
    logic [LEVEL_W-1:0] hopper_level;
    logic               hopper_empty;
    logic               feeding;
    logic [15:0]        dispensed_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pill_feeder_sim #(
        .PERIOD     (PERIOD),
        .PULSE_W    (PULSE_W),
        .CAPACITY   (CAPACITY),
        .REFILL_AMT (REFILL_AMT),
        .INIT_LEVEL (INIT_LEVEL),
        .LEVEL_W    (LEVEL_W)
    ) dut (
        .clk_1khz      (clk_1khz),
        .rst           (rst),
        .feed_en       (feed_en),
        .hopper_stop   (hopper_stop),
        .conveyor_stop (conveyor_stop),
        .hopper_add    (hopper_add),
        .pill_pulse    (pill_pulse),
        .hopper_level  (hopper_level),
        .hopper_empty  (hopper_empty),
        .feeding       (feeding),
        .dispensed_cnt (dispensed_cnt)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_refill(input int exp_level);
        hopper_add = 1'b1;
        repeat (ADD_TICKS) tick();
        check("refill_level", int'(hopper_level), exp_level);
        hopper_add = 1'b0;
        repeat (ADD_TICKS) tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_pulse", int'(pill_pulse), 0);
        check("rst_level", int'(hopper_level), INIT_LEVEL);
        check("rst_empty", int'(hopper_empty), 0);
        check("rst_feeding", int'(feeding), 0);
        check("rst_cnt", int'(dispensed_cnt), 0);
        $display("reset: level=%0d cnt=%0d", hopper_level, dispensed_cnt);

        // Continuous feed until the hopper runs dry
        rst = 1'b0;
        feed_en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check("t1_pulse", int'(pill_pulse), int'((((i - 1) % PERIOD) < PULSE_W) && (i <= 24)));
            check("t1_level", int'(hopper_level), (i < 11) ? 2 : (i < 21) ? 1 : 0);
            check("t1_empty", int'(hopper_empty), int'(i >= 31));
        end
        check("t1_cnt", int'(dispensed_cnt), 3);
        check("t1_feeding", int'(feeding), 0);
        repeat (5) tick();
        check("t1_no_4th", int'(pill_pulse), 0);
        $display("continuous feed: level=%0d cnt=%0d empty=%0d", hopper_level, dispensed_cnt, hopper_empty);

        // Refill from empty, then clamp at capacity
        hopper_add = 1'b1;
        repeat (ADD_TICKS - 1) tick();
        check("t2_pre_level", int'(hopper_level), 0);
        tick();
        check("t2_level", int'(hopper_level), 8);
        check("t2_still_empty", int'(hopper_empty), 1);
        tick();
        check("t2_idle_empty", int'(hopper_empty), 0);
        check("t2_idle_pulse", int'(pill_pulse), 0);
        check("t2_idle_feeding", int'(feeding), 0);
        tick();
        check("t2_pulse", int'(pill_pulse), 1);
        check("t2_level_dec", int'(hopper_level), 7);
        check("t2_cnt", int'(dispensed_cnt), 4);
        feed_en = 1'b0;
        hopper_add = 1'b0;
        repeat (ADD_TICKS) tick();
        do_refill(15);
        do_refill(CAPACITY);
        check("t2_idle_after", int'(feeding), 0);
        $display("refill: level=%0d cnt=%0d", hopper_level, dispensed_cnt);

        // Interlock raised mid-pulse
        feed_en = 1'b1;
        tick();
        check("t3_pulse_1", int'(pill_pulse), 1);
        check("t3_level", int'(hopper_level), 19);
        tick();
        check("t3_pulse_2", int'(pill_pulse), 1);
        hopper_stop = 1'b1;
        for (int j = 3; j <= 14; j++) begin
            tick();
            check("t3_pulse", int'(pill_pulse), int'(j <= PULSE_W));
            check("t3_feeding", int'(feeding), int'(j <= PERIOD));
        end
        hopper_stop = 1'b0;
        tick();
        check("t3_restart_pulse", int'(pill_pulse), 1);
        check("t3_restart_level", int'(hopper_level), 18);
        check("t3_cnt", int'(dispensed_cnt), 6);
        $display("interlock: level=%0d cnt=%0d", hopper_level, dispensed_cnt);

        // Reset during PULSE_HI
        feed_en = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_pulse", int'(pill_pulse), 0);
        check("t5_level", int'(hopper_level), INIT_LEVEL);
        check("t5_cnt", int'(dispensed_cnt), 0);
        check("t5_feeding", int'(feeding), 0);
        check("t5_empty", int'(hopper_empty), 0);
        rst = 1'b0;
        $display("reset mid-pulse: level=%0d cnt=%0d", hopper_level, dispensed_cnt);

        // Refill lands on the same edge as the pill that takes the level 1 -> 0
        for (int g = -1; g <= 21; g++) begin
            feed_en = (g >= 1);
            hopper_add = (g >= 22 - ADD_TICKS);
            tick();
            if (g == 20) check("t4_pre_level", int'(hopper_level), 1);
            if (g == 21) begin
                check("t4_level", int'(hopper_level), 8);
                check("t4_cnt", int'(dispensed_cnt), 3);
                check("t4_pulse", int'(pill_pulse), 1);
            end
        end
        feed_en = 1'b0;
        hopper_add = 1'b0;
        repeat (ADD_TICKS + 12) tick();
        check("t4_idle", int'(feeding), 0);
        check("t4_level_hold", int'(hopper_level), 8);
        $display("simultaneous: level=%0d cnt=%0d", hopper_level, dispensed_cnt);

        // Bouncing refill switch: rises at 0, 2, 4, then held high
        for (int h = 0; h <= 35; h++) begin
            int exp_level;
            hopper_add = (h < 5) ? ((h % 2) == 0) : (h < 34);
            tick();
`ifdef PILL_FEEDER_ADD_DEBOUNCE_EN
            exp_level = (h < 26) ? 8 : 16;
`else
            exp_level = (h < 2) ? 8 : (h < 4) ? 16 : CAPACITY;
`endif
            check("t6_level", int'(hopper_level), exp_level);
        end
        hopper_add = 1'b0;
        $display("bounce: level=%0d", hopper_level);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
